// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Accept edge registers operands, next edge captures the result, held until the owner takes it.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [WIDTH-1:0]  Req0A,
  input  logic [WIDTH-1:0]  Req0B,
  input  logic [CTRL_W-1:0] Req0Ctrl,
  output logic              Rsp0Valid,
  input  logic              Rsp0Ready,
  output logic [WIDTH-1:0]  Rsp0Result,
  output logic              Rsp0Zero,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [WIDTH-1:0]  Req1A,
  input  logic [WIDTH-1:0]  Req1B,
  input  logic [CTRL_W-1:0] Req1Ctrl,
  output logic              Rsp1Valid,
  input  logic              Rsp1Ready,
  output logic [WIDTH-1:0]  Rsp1Result,
  output logic              Rsp1Zero,
  output logic [WIDTH-1:0]  ScrA,
  output logic [WIDTH-1:0]  ScrB,
  output logic [CTRL_W-1:0] AluControl,
  input  logic [WIDTH-1:0]  ALUResult,
  input  logic              zero,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   scr_a_q, scr_a_d;
  logic [WIDTH-1:0]   scr_b_q, scr_b_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               grant;
  logic               any_vld;
  logic               rsp_rdy;

  // Contention goes to the requester named by prio; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (Req0Valid && Req1Valid) begin
      grant = prio_q;
    end else if (Req1Valid) begin
      grant = 1'b1;
    end
  end

  assign any_vld   = Req0Valid | Req1Valid;
  assign Req0Ready = !reset && (state_q == IDLE) && !grant && Req0Valid;
  assign Req1Ready = !reset && (state_q == IDLE) &&  grant && Req1Valid;
  assign rsp_rdy   = owner_q ? Rsp1Ready : Rsp0Ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    scr_a_d = scr_a_q;
    scr_b_d = scr_b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          scr_a_d = grant ? Req1A    : Req0A;
          scr_b_d = grant ? Req1B    : Req0B;
          ctrl_d  = grant ? Req1Ctrl : Req0Ctrl;
          owner_d = grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = ALUResult;
        zero_d  = zero;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      scr_a_q <= '0;
      scr_b_q <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      scr_a_q <= scr_a_d;
      scr_b_q <= scr_b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign ScrA       = scr_a_q;
  assign ScrB       = scr_b_q;
  assign AluControl = ctrl_q;
  assign Busy       = (state_q != IDLE);
  assign Rsp0Valid  = (state_q == RESP) && !owner_q;
  assign Rsp1Valid  = (state_q == RESP) &&  owner_q;
  assign Rsp0Result = res_q;
  assign Rsp1Result = res_q;
  assign Rsp0Zero   = zero_q;
  assign Rsp1Zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, with a
// transaction-level model predicting grants and a scoreboard checking responses.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, Rsp0Zero, Rsp1Zero, Busy, zero;
  logic [31:0] Rsp0Result, Rsp1Result, ScrA, ScrB, ALUResult;
  logic [2:0]  AluControl;

  logic        v  [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic [2:0]  c  [2];
  logic        rr [2];
  logic        acc[2];
  logic        rnd;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
  } exp_t;
  exp_t q[$];
  int   acc_hist[$];

  // Transaction-level model: is an operation outstanding, who owns it, whose turn it is.
  logic        busy_m, owner_m, prio_m;
  int          acc_cyc;
  logic [31:0] acc_a, acc_b;
  logic [2:0]  acc_c;
  int          cyc;
  int          n_chk, n_pass;

  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    case (op)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x & y;
      3'b011:  return x | y;
      3'b101:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x ^ y;
    endcase
  endfunction

  assign ALUResult = alu_f(ScrA, ScrB, AluControl);
  assign zero      = (ALUResult == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset),
    .Req0Valid(v[0]), .Req0Ready(Req0Ready), .Req0A(a[0]), .Req0B(b[0]), .Req0Ctrl(c[0]),
    .Rsp0Valid(Rsp0Valid), .Rsp0Ready(rr[0]), .Rsp0Result(Rsp0Result), .Rsp0Zero(Rsp0Zero),
    .Req1Valid(v[1]), .Req1Ready(Req1Ready), .Req1A(a[1]), .Req1B(b[1]), .Req1Ctrl(c[1]),
    .Rsp1Valid(Rsp1Valid), .Rsp1Ready(rr[1]), .Rsp1Result(Rsp1Result), .Rsp1Zero(Rsp1Zero),
    .ScrA(ScrA), .ScrB(ScrB), .AluControl(AluControl),
    .ALUResult(ALUResult), .zero(zero), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Grant prediction, handshake checks and scoreboard push, evaluated on the falling edge.
  task automatic model_step();
    int          w;
    logic [31:0] r;
    w = -1;
    if (!busy_m) begin
      if (v[0] && v[1]) w = int'(prio_m);
      else if (v[0])    w = 0;
      else if (v[1])    w = 1;
    end
    check("req0_ready", 32'(Req0Ready), 32'(w == 0));
    check("req1_ready", 32'(Req1Ready), 32'(w == 1));
    check("busy", 32'(Busy), 32'(busy_m));
    if (busy_m && cyc == acc_cyc + 1) begin
      check("scr_a", ScrA, acc_a);
      check("scr_b", ScrB, acc_b);
      check("alu_ctrl", 32'(AluControl), 32'(acc_c));
    end
    if (w >= 0) begin
      r = alu_f(a[w], b[w], c[w]);
      q.push_back('{id: 1'(w), res: r, z: (r == 32'd0)});
      acc_hist.push_back(cyc);
      acc[w]  = 1'b1;
      busy_m  <= 1'b1;
      owner_m <= 1'(w);
      acc_cyc <= cyc;
      acc_a   <= a[w];
      acc_b   <= b[w];
      acc_c   <= c[w];
    end
  endtask

  // Monitor: response valids, held result/zero, and scoreboard pop on handshake.
  logic        mon_v, mon_exp, mon_rdy, mon_z;
  logic [31:0] mon_res;
  always @(negedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        mon_exp = busy_m && (owner_m == 1'(n)) && (cyc >= acc_cyc + 2);
        mon_v   = (n == 0) ? Rsp0Valid  : Rsp1Valid;
        mon_rdy = (n == 0) ? rr[0]      : rr[1];
        mon_res = (n == 0) ? Rsp0Result : Rsp1Result;
        mon_z   = (n == 0) ? Rsp0Zero   : Rsp1Zero;
        check((n == 0) ? "rsp0_valid" : "rsp1_valid", 32'(mon_v), 32'(mon_exp));
        if (mon_exp && mon_v) begin
          if (q.size() == 0) begin
            check("scoreboard_nonempty", 32'(q.size()), 32'd1);
          end else begin
            check("rsp_owner",  32'(n), 32'(q[0].id));
            check("rsp_result", mon_res, q[0].res);
            check("rsp_zero",   32'(mon_z), 32'(q[0].z));
            if (mon_rdy) begin
              void'(q.pop_front());
              busy_m <= 1'b0;
              prio_m <= ~owner_m;
            end
          end
        end
      end
    end
  end

  task automatic drive_update();
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        v[i]   = 1'b0;
        acc[i] = 1'b0;
      end
      if (rnd) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1'b1;
          b[i] = ($urandom % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
          a[i] = ($urandom % 4 == 0) ? b[i] : (($urandom % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom);
          c[i] = 3'($urandom_range(0, 7));
        end else if (v[i] && ($urandom % 16 == 0)) begin
          v[i] = 1'b0;
        end
        rr[i] = ($urandom % 4) != 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive_update();
  endtask

  task automatic issue(input int i, input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xc);
    v[i] = 1'b1;
    a[i] = xa;
    b[i] = xb;
    c[i] = xc;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((v[0] || v[1] || busy_m || q.size() != 0) && k < 300) begin
      step();
      k++;
    end
    check("quiet_timeout", 32'(v[0] || v[1] || busy_m || (q.size() != 0)), 32'd0);
  endtask

  task automatic clear_model();
    q.delete();
    busy_m = 1'b0;
    owner_m = 1'b0;
    prio_m = 1'b0;
    acc_cyc = -10;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; rnd = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = '0; b[i] = '0; c[i] = '0; rr[i] = 1'b1;
    end
    clear_model();
    v[0] = 1'b1;
    v[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req0_ready", 32'(Req0Ready), 32'd0);
    check("rst_req1_ready", 32'(Req1Ready), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_rsp_valid", 32'({Rsp0Valid, Rsp1Valid}), 32'd0);
    check("rst_scr", ScrA | ScrB | 32'(AluControl), 32'd0);
    check("rst_result", Rsp0Result | 32'(Rsp0Zero), 32'd0);
    v[0] = 1'b0;
    v[1] = 1'b0;
    reset = 1'b0;

    issue(0, 32'd5, 32'd3, 3'b000);
    wait_quiet();
    issue(1, 32'd7, 32'd7, 3'b001);
    wait_quiet();

    // Contention straight out of reset, responses always taken.
    @(posedge clk); #1;
    reset = 1'b1; #2; clear_model();
    @(posedge clk); #1; reset = 1'b0;
    acc_hist.delete();
    issue(0, 32'd1, 32'd1, 3'b000);
    issue(1, 32'd10, 32'd4, 3'b001);
    wait_quiet();
    check("contention_accepts", 32'(acc_hist.size()), 32'd2);
    if (acc_hist.size() == 2) check("accept_spacing", 32'(acc_hist[1] - acc_hist[0]), 32'd3);

    issue(0, 32'd20, 32'd22, 3'b011);
    wait_quiet();
    issue(0, 32'd9, 32'd4, 3'b010);
    issue(1, 32'd3, 32'd9, 3'b101);
    wait_quiet();

    // Response backpressure with the other requester waiting.
    rr[0] = 1'b0;
    issue(0, 32'hFFFF_FFFF, 32'd1, 3'b000);
    step(); step(); step();
    issue(1, 32'd12, 32'd5, 3'b001);
    repeat (4) step();
    rr[0] = 1'b1;
    wait_quiet();

    // Leave prio at 1, then abandon an operation by resetting during EXEC.
    issue(0, 32'd2, 32'd2, 3'b000);
    wait_quiet();
    issue(1, 32'd9, 32'd9, 3'b001);
    @(negedge clk); model_step();
    @(posedge clk); #1; drive_update();
    issue(0, 32'd4, 32'd6, 3'b000);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_rsp_valid", 32'({Rsp0Valid, Rsp1Valid}), 32'd0);
    check("mid_rst_ready", 32'({Req0Ready, Req1Ready}), 32'd0);
    check("mid_rst_scr", ScrA | ScrB | 32'(AluControl), 32'd0);
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    issue(1, 32'd6, 32'd1, 3'b001);
    wait_quiet();

    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    wait_quiet();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
